// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared types and constants for the RISC core and its memory arbiter
package risc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_t;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  localparam logic [5:0] OP_HLT = 6'h3f;

endpackage

// File: rtl/risc_starve_counter.sv
// rtl/risc_starve_counter.sv - saturating counter of data grants taken while a fetch waits
module risc_starve_counter
  import risc_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk1,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_max
);

  localparam int CW = $clog2(MAX + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != CW'(MAX))) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_max = (r_cnt == CW'(MAX));

endmodule

// File: rtl/risc_mem_arbiter.sv
// rtl/risc_mem_arbiter.sv - shares one memory port between fetch and load/store, data first
module risc_mem_arbiter
  import risc_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int MAX_STARVE = 4
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  input  logic          halted,
  output logic          stall_if,
  output logic          stall_dm,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_t    r_state;
  arb_state_t    w_next;
  logic          w_if_elig;
  logic          w_starved;
  logic          w_gnt_if;
  logic          w_gnt_dm;
  logic          r_mem_req;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_if_rvalid;
  logic          r_dm_rvalid;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_dm_rdata;

  assign w_if_elig = if_req & ~halted;

  // Counts only while a fetch is actually being passed over; any gap in the fetch demand resets it.
  risc_starve_counter #(
    .MAX (MAX_STARVE)
  ) u_starve (
    .clk1  (clk1),
    .rst_n (rst_n),
    .i_clr (w_gnt_if | ~w_if_elig),
    .i_inc (w_gnt_dm & w_if_elig),
    .o_max (w_starved)
  );

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_gnt_dm = 1'b0;
    w_gnt_if = 1'b0;
    case (r_state)
      IDLE: begin
        if (dm_req && !(w_if_elig && w_starved)) begin
          w_gnt_dm = 1'b1;
          w_next   = BUSY_DM;
        end else if (w_if_elig) begin
          w_gnt_if = 1'b1;
          w_next   = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ack) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      if (w_gnt_dm || w_gnt_if) begin
        r_mem_req  <= 1'b1;
        r_mem_we   <= w_gnt_dm & dm_we;
        r_mem_addr <= w_gnt_dm ? dm_addr : if_addr;
        if (w_gnt_dm) r_mem_wdata <= dm_wdata;
      end else if ((r_state != IDLE) && mem_ack) begin
        r_mem_req <= 1'b0;
        if (r_state == BUSY_IF) begin
          r_if_rvalid <= 1'b1;
          r_if_rdata  <= mem_rdata;
        end else begin
          r_dm_rvalid <= 1'b1;
          // A store completion carries no data; keep the last load result.
          if (!r_mem_we) r_dm_rdata <= mem_rdata;
        end
      end
    end
  end

  assign if_gnt    = w_gnt_if;
  assign dm_gnt    = w_gnt_dm;
  assign if_rvalid = r_if_rvalid;
  assign dm_rvalid = r_dm_rvalid;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign stall_if  = (if_req & ~w_gnt_if) | (r_state == BUSY_IF);
  assign stall_dm  = (dm_req & ~w_gnt_dm) | (r_state == BUSY_DM);

endmodule
